// File: rtl/test_sink_if.sv
// AXI-Stream style link carrying 2-bit {I,Q} symbols into the test sink.
interface test_sink_if;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;

  // Upstream driver of the link
  modport master (output in_valid, output in_data, input in_ready);
  // Terminating sink
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/test_sink.sv
// Receive-side checker for the toggling 2-bit I/Q test pattern (v, ~v, v, ...).
// Tracks pattern lock, flags mismatches while locked, counts beats/errors and
// optionally throttles in_ready to exercise upstream back-pressure.
module test_sink #(
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned LOSS_CNT     = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned READY_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst,
  test_sink_if.slave       axis_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned GR_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int unsigned BR_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
  localparam int unsigned RP_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_have_prev;
  logic [1:0]       r_prev;
  logic [GR_W-1:0]  r_good_run;
  logic [BR_W-1:0]  r_bad_run;
  logic             r_locked;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_accept;
  logic             w_good;
  logic [GR_W-1:0]  w_good_inc;
  logic [BR_W-1:0]  w_bad_inc;

  assign w_accept   = axis_in.in_valid & r_in_ready;
  assign w_good     = r_have_prev & (axis_in.in_data == ~r_prev);
  assign w_good_inc = r_good_run + GR_W'(1);
  assign w_bad_inc  = r_bad_run + BR_W'(1);

  if (READY_PERIOD == 0) begin : g_ready_const
    // Ready rises on the first edge after reset and stays high
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_in_ready <= 1'b0;
      else      r_in_ready <= 1'b1;
    end
  end else begin : g_ready_throttle
    logic [RP_W-1:0] r_rcnt;
    // Free-running 0..N-1 counter; ready drops for one cycle per period
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rcnt     <= '0;
        r_in_ready <= 1'b0;
      end else begin
        r_in_ready <= (r_rcnt != RP_W'(READY_PERIOD - 1));
        r_rcnt     <= (r_rcnt == RP_W'(READY_PERIOD - 1)) ? '0 : r_rcnt + RP_W'(1);
      end
    end
  end

  // Lock state machine, pattern check and saturating statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_SEARCH;
      r_have_prev <= 1'b0;
      r_prev      <= 2'b00;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_locked    <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_err_flag <= 1'b0;
      if (clear) begin
        // Clear wins over a simultaneous beat, which is consumed unchecked
        r_state     <= S_SEARCH;
        r_have_prev <= 1'b0;
        r_good_run  <= '0;
        r_bad_run   <= '0;
        r_locked    <= 1'b0;
        r_err_cnt   <= '0;
        r_beat_cnt  <= '0;
      end else if (w_accept) begin
        // prev follows every beat so the checker re-aligns to any phase
        r_prev      <= axis_in.in_data;
        r_have_prev <= 1'b1;
        case (r_state)
          S_SEARCH: begin
            if (!w_good) begin
              r_good_run <= '0;
            end else if (w_good_inc == GR_W'(LOCK_CNT)) begin
              r_state    <= S_LOCKED;
              r_locked   <= 1'b1;
              r_good_run <= '0;
              r_bad_run  <= '0;
            end else begin
              r_good_run <= w_good_inc;
            end
          end
          S_LOCKED: begin
            if (r_beat_cnt != CNT_MAX) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_good) begin
              r_bad_run <= '0;
            end else begin
              if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
              r_err_flag <= 1'b1;
              if (w_bad_inc == BR_W'(LOSS_CNT)) begin
                r_state    <= S_SEARCH;
                r_locked   <= 1'b0;
                r_good_run <= '0;
                r_bad_run  <= '0;
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

  assign axis_in.in_ready = r_in_ready;
  assign locked           = r_locked;
  assign err_flag         = r_err_flag;
  assign err_cnt          = r_err_cnt;
  assign beat_cnt         = r_beat_cnt;

endmodule

// File: tb/tb_test_sink.sv
// Bench for test_sink: two instances (always-ready default and throttled/narrow),
// a behavioural model per instance compared every cycle, plus literal checkpoints.
module tb_test_sink;

  logic clk;
  logic rst;
  logic clr0, clr1;
  logic lk0, lk1, ef0, ef1;
  logic [15:0] ec0, bc0;
  logic [3:0]  ec1, bc1;

  int total = 0;
  int bad   = 0;

  test_sink_if if0();
  test_sink_if if1();

  test_sink #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16), .READY_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst), .axis_in(if0), .clear(clr0),
    .locked(lk0), .err_flag(ef0), .err_cnt(ec0), .beat_cnt(bc0));

  test_sink #(.LOCK_CNT(4), .LOSS_CNT(30), .CNT_W(4), .READY_PERIOD(4)) dut1 (
    .clk(clk), .rst(rst), .axis_in(if1), .clear(clr1),
    .locked(lk1), .err_flag(ef1), .err_cnt(ec1), .beat_cnt(bc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         k;          // edges seen since reset
    bit         have_prev;
    logic [1:0] prev;
    bit         locked;
    int         good_run;
    int         bad_run;
    int         errs;
    int         beats;
    bit         flag;
  } mdl_t;

  mdl_t m0, m1;

  // Ready after k edges: low on every period-th edge, high otherwise
  function automatic bit mready(input int k, input int period);
    if (k == 0) return 1'b0;
    if (period == 0) return 1'b1;
    return (k % period) != 0;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input logic v, input logic [1:0] d,
                                 input logic clr, input int lock_n, input int loss_n,
                                 input int maxc, input int period);
    mdl_t n;
    bit acc;
    bit good;
    n = s;
    acc = (v === 1'b1) && mready(s.k, period);
    n.k = s.k + 1;
    n.flag = 1'b0;
    if (clr === 1'b1) begin
      n.have_prev = 1'b0; n.locked = 1'b0; n.good_run = 0; n.bad_run = 0;
      n.errs = 0; n.beats = 0;
    end else if (acc) begin
      good = s.have_prev && (d == ~s.prev);
      n.prev = d;
      n.have_prev = 1'b1;
      if (!s.locked) begin
        n.good_run = good ? s.good_run + 1 : 0;
        if (n.good_run >= lock_n) begin
          n.locked = 1'b1;
          n.good_run = 0;
          n.bad_run = 0;
        end
      end else begin
        n.beats = (s.beats < maxc) ? s.beats + 1 : maxc;
        if (good) n.bad_run = 0;
        else begin
          n.errs = (s.errs < maxc) ? s.errs + 1 : maxc;
          n.flag = 1'b1;
          n.bad_run = s.bad_run + 1;
          if (n.bad_run >= loss_n) begin
            n.locked = 1'b0;
            n.bad_run = 0;
            n.good_run = 0;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= '{default: 0};
      m1 <= '{default: 0};
    end else begin
      m0 <= mstep(m0, if0.in_valid, if0.in_data, clr0, 4, 3, 65535, 0);
      m1 <= mstep(m1, if1.in_valid, if1.in_data, clr1, 4, 30, 15, 4);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("d0_ready",  32'(if0.in_ready), 32'(mready(m0.k, 0)));
    chk("d0_locked", 32'(lk0), 32'(m0.locked));
    chk("d0_flag",   32'(ef0), 32'(m0.flag));
    chk("d0_errs",   32'(ec0), 32'(m0.errs));
    chk("d0_beats",  32'(bc0), 32'(m0.beats));
    chk("d1_ready",  32'(if1.in_ready), 32'(mready(m1.k, 4)));
    chk("d1_locked", 32'(lk1), 32'(m1.locked));
    chk("d1_flag",   32'(ef1), 32'(m1.flag));
    chk("d1_errs",   32'(ec1), 32'(m1.errs));
    chk("d1_beats",  32'(bc1), 32'(m1.beats));
  end

  // ---------------- stimulus ----------------
  task automatic send0(input logic [1:0] d);
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    @(negedge clk);
  endtask

  // Present d on dut1 until accepted (data held across stall cycles)
  task automatic send1(input logic [1:0] d);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = d;
      acc = (if1.in_ready === 1'b1);
      @(negedge clk);
    end
    chk("d1_accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [1:0] cur;
    logic [1:0] last1;
    int ones;
    int nflag;
    rst = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = 2'b00;
    if1.in_valid = 1'b0; if1.in_data = 2'b00;
    @(negedge clk);
    chk("rst_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_beats", 32'(bc0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready", 32'(if0.in_ready), 32'd1);

    // 1: lock on five toggling beats, counting starts at the sixth
    send0(2'b00); send0(2'b11); send0(2'b00); send0(2'b11);
    chk("t1_not_yet", 32'(lk0), 32'd0);
    send0(2'b00);
    chk("t1_locked", 32'(lk0), 32'd1);
    chk("t1_beats0", 32'(bc0), 32'd0);
    send0(2'b11); send0(2'b00);
    chk("t1_beats2", 32'(bc0), 32'd2);

    // 2: a repeated symbol gives one error, lock held
    send0(2'b11); send0(2'b11);
    chk("t2_flag", 32'(ef0), 32'd1);
    chk("t2_errs", 32'(ec0), 32'd1);
    send0(2'b00);
    chk("t2_flag_gone", 32'(ef0), 32'd0);
    chk("t2_locked", 32'(lk0), 32'd1);

    // 3: three mismatches drop lock, four toggles regain it
    send0(2'b00); send0(2'b00);
    chk("t3_still", 32'(lk0), 32'd1);
    send0(2'b00);
    chk("t3_lost", 32'(lk0), 32'd0);
    chk("t3_errs", 32'(ec0), 32'd4);
    send0(2'b11); send0(2'b00); send0(2'b11); send0(2'b00);
    chk("t3_relock", 32'(lk0), 32'd1);
    chk("t3_beats", 32'(bc0), 32'd8);
    if0.in_valid = 1'b0;

    // 4: throttled ready, valid held, data advances only on accept
    send1(2'b00); send1(2'b11); send1(2'b00); send1(2'b11); send1(2'b00);
    chk("t4_locked", 32'(lk1), 32'd1);
    chk("t4_beats0", 32'(bc1), 32'd0);
    cur = 2'b11;
    ones = 0;
    for (int c = 0; c < 8; c++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = cur;
      if (if1.in_ready === 1'b1) begin
        ones++;
        cur = ~cur;
      end
      @(negedge clk);
    end
    chk("t4_ready_ones", 32'(ones), 32'd6);
    chk("t4_beats6", 32'(bc1), 32'd6);
    chk("t4_errs", 32'(ec1), 32'd0);
    last1 = ~cur;

    // 5: twenty mismatches saturate the narrow error counter
    nflag = 0;
    for (int e = 0; e < 20; e++) begin
      send1(last1);
      if (ef1 === 1'b1) nflag++;
    end
    if1.in_valid = 1'b0;
    chk("t5_flags", 32'(nflag), 32'd20);
    chk("t5_errs_sat", 32'(ec1), 32'd15);
    chk("t5_beats_sat", 32'(bc1), 32'd15);
    chk("t5_locked", 32'(lk1), 32'd1);

    // 6a: asynchronous reset between edges clears outputs at once
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_locked", 32'(lk0), 32'd0);
    chk("t6_async_beats", 32'(bc0), 32'd0);
    chk("t6_async_errs1", 32'(ec1), 32'd0);
    chk("t6_async_ready", 32'(if0.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 6b: clear with a simultaneous beat; that beat is not checked
    send0(2'b00); send0(2'b11); send0(2'b00); send0(2'b11); send0(2'b00);
    send0(2'b11);
    chk("t6_locked", 32'(lk0), 32'd1);
    chk("t6_beats1", 32'(bc0), 32'd1);
    clr0 = 1'b1;
    send0(2'b11);
    clr0 = 1'b0;
    chk("t6_clr_locked", 32'(lk0), 32'd0);
    chk("t6_clr_beats", 32'(bc0), 32'd0);
    chk("t6_clr_errs", 32'(ec0), 32'd0);
    chk("t6_clr_flag", 32'(ef0), 32'd0);
    send0(2'b00); send0(2'b11); send0(2'b00); send0(2'b11);
    chk("t6_unchecked", 32'(lk0), 32'd0);
    send0(2'b00);
    chk("t6_relock", 32'(lk0), 32'd1);
    if0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
